// File: rtl/axi_logger_ctrl_pkg.sv
// Shared types and sizing helpers for the AXI logger run-control sequencer.
package axi_logger_ctrl_pkg;

    typedef enum logic [2:0] {
        CLEARING   = 3'd0,
        WAIT_READY = 3'd1,
        IDLE       = 3'd2,
        LOGGING    = 3'd3,
        STOPPED    = 3'd4
    } state_t;

    // Width of a counter that must be able to hold the value clear_min_cycles.
    function automatic int clr_cnt_bitw(input int clear_min_cycles);
        return $clog2(clear_min_cycles + 1);
    endfunction

endpackage

// File: rtl/axi_logger_ctrl.sv
// Run-control sequencer for a bank of AXI BRAM loggers: clear, wait for ready,
// start/stop logging, sticky full tracking and a saturating logging-duration count.
module axi_logger_ctrl
    import axi_logger_ctrl_pkg::*;
#(
    parameter int NUM_LOGGERS      = 2,
    parameter int CLEAR_MIN_CYCLES = 4,
    parameter int DUR_CNT_BITW     = 32
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic                    CmdStart_SI,
    input  logic                    CmdStop_SI,
    input  logic                    CmdClear_SI,
    input  logic                    StopOnFull_SI,
    input  logic [NUM_LOGGERS-1:0]  LoggerFull_SI,
    input  logic [NUM_LOGGERS-1:0]  LoggerReady_SI,
    output logic [NUM_LOGGERS-1:0]  LoggerClear_SO,
    output logic [NUM_LOGGERS-1:0]  LoggerEn_SO,
    output logic [2:0]              State_DO,
    output logic [NUM_LOGGERS-1:0]  FullMask_DO,
    output logic                    FullIrq_SO,
    output logic                    CmdErr_SO,
    output logic [DUR_CNT_BITW-1:0] DurCnt_DO
);

    localparam int CLR_CNT_BITW = clr_cnt_bitw(CLEAR_MIN_CYCLES);
    localparam logic [CLR_CNT_BITW-1:0] CLR_LAST  = CLR_CNT_BITW'(CLEAR_MIN_CYCLES);
    localparam logic [CLR_CNT_BITW-1:0] CLR_FIRST = CLR_CNT_BITW'(1);
    localparam logic [DUR_CNT_BITW-1:0] DUR_ONE   = DUR_CNT_BITW'(1);

    state_t                  state_q, state_d;
    logic [CLR_CNT_BITW-1:0] clr_cnt_q, clr_cnt_d;
    logic                    clear_q, clear_d;
    logic                    en_q, en_d;
    logic [NUM_LOGGERS-1:0]  mask_q, mask_d;
    logic                    irq_q, irq_d;
    logic                    err_q, err_d;
    logic [DUR_CNT_BITW-1:0] dur_q, dur_d;

    // Commands are one-cycle pulses sampled on every edge; the bank counts as
    // ready only when every LoggerReady bit is high. Priority: clear > stop > start.
    logic do_clear, do_stop, do_start, any_cmd, clear_ok;
    assign do_clear = CmdClear_SI;
    assign do_stop  = CmdStop_SI & ~CmdClear_SI;
    assign do_start = CmdStart_SI & ~CmdStop_SI & ~CmdClear_SI;
    assign any_cmd  = CmdStart_SI | CmdStop_SI | CmdClear_SI;
    assign clear_ok = (state_q == IDLE) || (state_q == LOGGING) || (state_q == STOPPED);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clear_d   = 1'b0;
        en_d      = 1'b0;
        mask_d    = mask_q;
        dur_d     = dur_q;
        err_d     = 1'b0;

        if (state_q == LOGGING || state_q == STOPPED) begin
            mask_d = mask_q | LoggerFull_SI;
        end

        case (state_q)
            CLEARING: begin
                mask_d = '0;
                dur_d  = '0;
                err_d  = any_cmd;
                if (clr_cnt_q >= CLR_LAST) begin
                    state_d = WAIT_READY;
                end else begin
                    clear_d   = 1'b1;
                    clr_cnt_d = clr_cnt_q + CLR_FIRST;
                end
            end
            WAIT_READY: begin
                err_d = any_cmd;
                if (&LoggerReady_SI) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (do_start) begin
                    state_d = LOGGING;
                    en_d    = 1'b1;
                end
            end
            LOGGING: begin
                if (dur_q != '1) begin
                    dur_d = dur_q + DUR_ONE;
                end
                if (do_stop || (StopOnFull_SI && |LoggerFull_SI)) begin
                    state_d = STOPPED;
                end else begin
                    en_d = 1'b1;
                end
            end
            STOPPED: begin
                if (do_start) begin
                    if (StopOnFull_SI && |mask_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOGGING;
                        en_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = CLEARING;
                clr_cnt_d = '0;
            end
        endcase

        // The entry cycle already drives clear high, so it counts as the first clear cycle.
        if (do_clear && clear_ok) begin
            state_d   = CLEARING;
            clear_d   = 1'b1;
            en_d      = 1'b0;
            clr_cnt_d = CLR_FIRST;
            mask_d    = '0;
            dur_d     = '0;
        end

        irq_d = (mask_q == '0) && (mask_d != '0);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= CLEARING;
            clr_cnt_q <= '0;
            clear_q   <= 1'b0;
            en_q      <= 1'b0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
            dur_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            clear_q   <= clear_d;
            en_q      <= en_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
            dur_q     <= dur_d;
        end
    end

    assign LoggerClear_SO = {NUM_LOGGERS{clear_q}};
    assign LoggerEn_SO    = {NUM_LOGGERS{en_q}};
    assign State_DO       = state_q;
    assign FullMask_DO    = mask_q;
    assign FullIrq_SO     = irq_q;
    assign CmdErr_SO      = err_q;
    assign DurCnt_DO      = dur_q;

endmodule
